// File: rtl/ransac_rsqrt_iter.sv
// ransac_rsqrt_iter: iterative fixed-point reciprocal square root.
// Computes y ~= 1/sqrt(a) with a power-of-two initial guess followed by
// ITERATIONS Newton-Raphson steps y <- y*(1.5 - a*y*y/2) on one shared multiplier.
// Optional feature macro RANSAC_RSQRT_SATURATE_EN: narrowed products and the initial
// guess clamp to the W-bit signed range and any clamp is reported in out_error;
// without it results wrap to the low W bits.
module ransac_rsqrt_iter #(
    parameter int INTEGRAL_BITS = 24,
    parameter int FRACTION_BITS = 24,
    parameter int ITERATIONS    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INTEGRAL_BITS+FRACTION_BITS-1:0] in_a,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INTEGRAL_BITS+FRACTION_BITS-1:0] out_y,
    output logic                                   out_error
);
    localparam int W  = INTEGRAL_BITS + FRACTION_BITS;
    localparam int W2 = 2 * W;

    localparam logic signed [W2-1:0] MaxWide = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [W2-1:0] MinWide = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic signed [W2-1:0] OneWide = {{(W2 - 1){1'b0}}, 1'b1} << FRACTION_BITS;
    localparam logic signed [W-1:0] ThreeHalves = {{(W - 2){1'b0}}, 2'b11} << (FRACTION_BITS - 1);

    typedef enum logic [2:0] {StIdle, StGuess, StSq, StMula, StUpd, StDone} state_e;

    state_e              state_q, state_d;
    logic signed [W-1:0] a_q, y_q, t_q;
    logic [3:0]          iter_q;
    logic                sat_q;
    logic                out_valid_q, out_error_q;
    logic [W-1:0]        out_y_q;

    logic signed [W-1:0]  mul_x, mul_y, half_term, mul_res, guess_res;
    logic signed [W2-1:0] prod, prod_shr, guess_wide;
    logic                 mul_clamp, guess_clamp, a_nonpos, last_iter;
    int                   msb, expo, shamt;

    // Narrow a wide value to W bits; MSB of the result flags a clamp.
    function automatic logic [W:0] fit(input logic signed [W2-1:0] v);
`ifdef RANSAC_RSQRT_SATURATE_EN
        if (v > MaxWide) begin
            return {1'b1, MaxWide[W-1:0]};
        end else if (v < MinWide) begin
            return {1'b1, MinWide[W-1:0]};
        end
        return {1'b0, v[W-1:0]};
`else
        return {1'b0, v[W-1:0]};
`endif
    endfunction

    assign a_nonpos  = a_q[W-1] || (a_q == '0);
    assign last_iter = (iter_q == 4'(ITERATIONS - 1));

    // Initial guess: one scaled by 2^-ceil(e/2), e being a's binary exponent.
    always_comb begin
        msb = 0;
        for (int i = 0; i < W; i++) begin
            if (a_q[i]) msb = i;
        end
        expo  = msb - FRACTION_BITS;
        shamt = (expo + 1) >>> 1;
        if (shamt >= 0) guess_wide = OneWide >>> shamt;
        else            guess_wide = OneWide <<< (-shamt);
        {guess_clamp, guess_res} = fit(guess_wide);
    end

    // Shared multiplier: operand select by step, floor-shift, narrow.
    always_comb begin
        half_term = ThreeHalves - (t_q >>> 1);
        mul_x     = y_q;
        mul_y     = y_q;
        if (state_q == StMula) begin
            mul_x = a_q;
            mul_y = t_q;
        end else if (state_q == StUpd) begin
            mul_x = y_q;
            mul_y = half_term;
        end
        prod     = mul_x * mul_y;
        prod_shr = prod >>> FRACTION_BITS;
        {mul_clamp, mul_res} = fit(prod_shr);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StGuess;
            StGuess: state_d = a_nonpos ? StDone : StSq;
            StSq:    state_d = StMula;
            StMula:  state_d = StUpd;
            StUpd:   state_d = last_iter ? StDone : StSq;
            StDone:  if (out_valid_q && out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            y_q         <= '0;
            t_q         <= '0;
            iter_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q    <= in_a;
                        iter_q <= '0;
                        sat_q  <= 1'b0;
                    end
                end
                StGuess: begin
                    if (a_nonpos) begin
                        out_y_q     <= '0;
                        out_error_q <= 1'b1;
                    end else begin
                        y_q   <= guess_res;
                        sat_q <= sat_q | guess_clamp;
                    end
                end
                StSq, StMula: begin
                    t_q   <= mul_res;
                    sat_q <= sat_q | mul_clamp;
                end
                StUpd: begin
                    y_q    <= mul_res;
                    sat_q  <= sat_q | mul_clamp;
                    iter_q <= iter_q + 4'd1;
                    if (last_iter) begin
                        out_y_q     <= mul_res;
                        out_error_q <= sat_q | mul_clamp;
                    end
                end
                StDone: begin
                    // Valid rises one cycle after entering DONE, drops on handshake.
                    if (!out_valid_q)   out_valid_q <= 1'b1;
                    else if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_error = out_error_q;

endmodule

// File: tb/tb_ransac_rsqrt_iter.sv
// Scoreboard bench for ransac_rsqrt_iter: directed operands plus random operands
// checked against an arithmetic reference model; a second small-format instance
// exercises the overflow behaviour.
module tb_ransac_rsqrt_iter;
    localparam int W  = 48;
    localparam int F  = 24;
    localparam int IT = 4;

    typedef logic signed [127:0] wide_t;
    typedef struct {
        logic [W-1:0] y;
        logic         err;
        int           lat;
        longint       tol;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_y;
    logic         out_error;

    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [15:0]  s_in_a = '0;
    logic         s_out_valid;
    logic [15:0]  s_out_y;
    logic         s_out_error;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   last_hs = 0;
    bit   in_flight = 0;
    bit   rnd_done = 0;
    logic [W-1:0] held_y;
    logic         held_err;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ransac_rsqrt_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_error(out_error)
    );

    ransac_rsqrt_iter #(.INTEGRAL_BITS(4), .FRACTION_BITS(12), .ITERATIONS(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_y(s_out_y), .out_error(s_out_error)
    );

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic wide_t floor_div(input wide_t n, input int k);
        wide_t d, q;
        d = wide_t'(1) <<< k;
        q = n / d;
        if (n < 0 && (n % d) != 0) q = q - 1;
        return q;
    endfunction

    function automatic wide_t wrap48(input wide_t v);
        wide_t r;
        r = {{80{v[47]}}, v[47:0]};
        return r;
    endfunction

    function automatic wide_t fit48(input wide_t v, inout logic flag);
`ifdef RANSAC_RSQRT_SATURATE_EN
        wide_t mx, mn;
        mx = (wide_t'(1) <<< 47) - 1;
        mn = -(wide_t'(1) <<< 47);
        if (v > mx) begin flag = 1'b1; return mx; end
        if (v < mn) begin flag = 1'b1; return mn; end
        return v;
`else
        return wrap48(v);
`endif
    endfunction

    task automatic model(input logic [W-1:0] a_bits, output logic [W-1:0] y_out,
                         output logic err_out);
        wide_t a, one, y, t, hf, yw;
        int p, e, s;
        logic flag;
        a   = {{80{a_bits[47]}}, a_bits};
        one = wide_t'(1) <<< F;
        if (a <= 0) begin
            y_out = '0;
            err_out = 1'b1;
            return;
        end
        p = 0;
        while ((wide_t'(1) <<< (p + 1)) <= a) p++;
        e = p - F;
        s = (e >= 0) ? (e + 1) / 2 : -((-e) / 2);
        flag = 1'b0;
        if (s >= 0) y = floor_div(one, s);
        else        y = one * (wide_t'(1) <<< (-s));
        y = fit48(y, flag);
        for (int k = 0; k < IT; k++) begin
            t  = fit48(floor_div(y * y, F), flag);
            t  = fit48(floor_div(a * t, F), flag);
            hf = wrap48(3 * (wide_t'(1) <<< (F - 1)) - floor_div(t, 1));
            y  = fit48(floor_div(y * hf, F), flag);
        end
        yw = y;
        y_out = yw[47:0];
        err_out = flag;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present an operand, wait (bounded) for acceptance, push the expected result.
    task automatic send(input logic [W-1:0] a, input bit use_model, input logic [W-1:0] y_req,
                        input logic err_req, input longint tol);
        exp_t e;
        int n;
        in_a = a;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            tick(1);
            return;
        end
        if (use_model) begin
            model(a, e.y, e.err);
        end else begin
            e.y = y_req;
            e.err = err_req;
        end
        e.lat = ($signed(a) <= 0) ? 2 : 2 + 3 * IT;
        e.tol = tol;
        e.acc = cyc + 1;
        last_acc = e.acc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0 || out_valid) fail_now("drain_timeout");
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            in_flight = 0;
        end else if (out_valid) begin
            if (!in_flight) begin
                in_flight = 1;
                held_y = out_y;
                held_err = out_error;
                if (sb.size() == 0) begin
                    fail_now("unexpected_valid");
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.tol == 0) begin
                        check("out_y", longint'(out_y), longint'(mon_e.y));
                    end else begin
                        longint d;
                        d = longint'($signed(out_y)) - longint'($signed(mon_e.y));
                        if (d < 0) d = -d;
                        total++;
                        if (d > mon_e.tol) begin
                            bad++;
                            $display("FAIL out_y_tol: got 0x%0h expected 0x%0h +/- %0d",
                                     out_y, mon_e.y, mon_e.tol);
                        end
                    end
                    check("out_error", longint'(out_error), longint'(mon_e.err));
                    check("latency", longint'(cyc - mon_e.acc), longint'(mon_e.lat));
                end
            end else begin
                check("hold_y", longint'(out_y), longint'(held_y));
                check("hold_err", longint'(out_error), longint'(held_err));
                check("hold_in_ready", longint'(in_ready), 0);
            end
            if (out_ready) begin
                in_flight = 0;
                last_hs = cyc + 1;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] r64;
        logic [W-1:0] a;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_y", longint'(out_y), 0);
        check("rst_out_error", longint'(out_error), 0);
        check("rst_s_in_ready", longint'(s_in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", longint'(in_ready), 1);
        check("s_in_ready_after_rst", longint'(s_in_ready), 1);
        tick(1);

        // Directed values, back to back.
        send(48'h000001_000000, 0, 48'h000001_000000, 1'b0, 0);
        send(48'h000000_400000, 0, 48'h000002_000000, 1'b0, 0);
        send(48'h000002_000000, 0, 48'd11863283, 1'b0, 16);
        send(48'hFFFFFF_000000, 0, '0, 1'b1, 0);
        send(48'h000000_000000, 0, '0, 1'b1, 0);
        drain();

        // Output held under backpressure, then back-to-back acceptance.
        out_ready = 1'b0;
        send(48'h000004_000000, 1, '0, 1'b0, 0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("hold_valid_timeout");
        repeat (5) @(negedge clk);
        tick(1);
        out_ready = 1'b1;
        send(48'h000000_400000, 1, '0, 1'b0, 0);
        check("back_to_back_accept", longint'(last_acc), longint'(last_hs + 1));
        drain();

        // Reset while in MULA discards the operation.
        send(48'h000001_000000, 1, '0, 1'b0, 0);
        tick(2);
        rst = 1'b1;
        void'(sb.pop_back());
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_mid_rst", longint'(in_ready), 1);
        tick(1);
        send(48'h000004_000000, 0, 48'h000000_800000, 1'b0, 0);
        drain();

        // Small format: tiny operand overflows the initial guess.
        s_in_a = 16'h0001;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!s_out_valid) begin
            fail_now("small_valid_timeout");
        end else begin
`ifdef RANSAC_RSQRT_SATURATE_EN
            check("small_out_y", longint'(s_out_y), 64'h7FFF);
            check("small_out_error", longint'(s_out_error), 1);
`else
            check("small_out_error", longint'(s_out_error), 0);
`endif
        end
        tick(1);

        // Random operands with random downstream backpressure.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    r64 = {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) begin
                        a = r64[47:0];
                        if ($urandom_range(0, 1) == 0) a = '0;
                        else a[47] = 1'b1;
                    end else begin
                        a = (r64[47:0] & 48'h7FFF_FFFF_FFFF) >> $urandom_range(0, 46);
                        if (a == '0) a = 48'd1;
                    end
                    send(a, 1, '0, 1'b0, 0);
                    tick($urandom_range(0, 3));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
